// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the bit-counter width helper.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter needs at least one bit even for a 1-bit adder.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit_cell.sv
// Purely combinational 1-bit full adder cell used by the serial adder.
module fa_bit_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: feeds one full-adder cell LSB first, one bit
// per clock, and presents a registered WIDTH-bit sum plus carry-out.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0] sr_shift;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s_bit, c_bit;
    logic             start_acc;
    logic             last_bit;

    fa_bit_cell u_fa (
        .x (sa[0]),
        .y (sb[0]),
        .z (carry),
        .s (s_bit),
        .c (c_bit)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shift = s_bit;
        end else begin : g_wn
            assign sr_shift = {s_bit, sr[WIDTH-1:1]};
        end
    endgenerate

    assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit  = (cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clear overrides everything.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clear) state_nxt = ST_IDLE;
    end

    // Operand/result shifting, carry and counter; sum/cout load only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (clear) begin
            carry <= 1'b0;
            cnt   <= '0;
        end else if (start_acc) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= sr_shift;
            carry <= c_bit;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= sr_shift;
                cout <= c_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for the bit-serial adder (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, clear, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1, clear1, cin1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1;

    int checks = 0;
    int errors = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_excl8", busy & done, 1'b0);
            if (done) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done8: got sum=%0h cout=%0b with empty scoreboard", sum, cout);
                end else begin
                    logic [8:0] e;
                    e = q8.pop_front();
                    check("result8", {cout, sum}, e);
                end
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got sum=%0h cout=%0b with empty scoreboard", sum1, cout1);
            end else begin
                logic [1:0] e;
                e = q1.pop_front();
                check("result1", {cout1, sum1}, e);
            end
        end
    end

    // Waits for done on the 8-bit instance; n counts negedges since the start edge.
    task automatic wait_done8(input int n0, output int n, output int nb);
        n  = n0;
        nb = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout8: got no done after %0d cycles, required done", n);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic [8:0] exp, input string name);
        int n, nb;
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        nb = busy ? 1 : 0;
        begin
            int n2, nb2;
            wait_done8(1, n2, nb2);
            n = n2;
            nb += nb2;
        end
        check({name, "_latency"}, n, 9);
        check({name, "_busy_cycles"}, nb, 8);
    endtask

    initial begin
        int n, nb;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; cin = 1'b0; a = '0; b = '0;
        start1 = 1'b0; clear1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        rst_n = 1'b1;

        // Basic additions
        run8(8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
        run8(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
        run8(8'hFF, 8'h00, 1'b1, 9'h100, "add_ff_00_c");
        run8(8'h00, 8'h00, 1'b0, 9'h000, "add_zero");

        // Start held through RUN with changing operands, then into DONE
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        q8.push_back(9'h030);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1;
        q8.push_back(9'h100);
        wait_done8(1, n, nb);
        check("held_start_latency", n, 9);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", busy, 1'b1);
        wait_done8(1, n, nb);
        check("b2b_latency", n, 9);

        // Asynchronous reset in RUN cycle 4
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_sum", sum, 8'h00);
        check("midrst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'h12, 8'h34, 1'b0, 9'h046, "add_after_rst");

        // Clear in RUN cycle 3 with start also high
        @(negedge clk);
        a = 8'h99; b = 8'h99; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1; start = 1'b1;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check("clear_busy", busy, 1'b0);
        check("clear_done", done, 1'b0);
        repeat (12) @(negedge clk);
        check("clear_keep_sum", sum, 8'h46);
        check("clear_keep_cout", cout, 1'b0);
        run8(8'h01, 8'h02, 1'b1, 9'h004, "add_after_clear");

        // WIDTH=1 instance
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        q1.push_back(2'b11);
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", busy1, 1'b1);
        check("w1_run_done", done1, 1'b0);
        @(negedge clk);
        check("w1_done", done1, 1'b1);
        check("w1_busy_off", busy1, 1'b0);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; start1 = 1'b1;
        q1.push_back(2'b01);
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("w1_done2", done1, 1'b1);

        repeat (3) @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder cell over a WIDTH-bit addition, one bit per clock, LSB first. It owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake. It is the low-area alternative to a WIDTH-wide ripple adder in the adder/decoder library.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request to begin an addition; sampled on rising clk.
clear  input  1  synchronous abort; returns the block to IDLE.
a  input  WIDTH  operand A, captured when start is accepted.
b  input  WIDTH  operand B, captured when start is accepted.
cin  input  1  carry-in, captured when start is accepted.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when sum/cout become valid.
sum  output  WIDTH  registered result; held until the next completion.
cout  output  1  registered carry-out; held with sum.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flop and counter all 0.
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: single cycle presenting the result.
- Start acceptance:
  - start=1 at an edge in IDLE or DONE → load a, b into shift regs sa, sb; load cin into the carry flop; counter=0; go to RUN.
  - start in RUN is ignored; operands are not re-sampled.
- RUN, each edge:
  - s = sa[0]^sb[0]^carry; c = majority(sa[0], sb[0], carry).
  - Result shift reg sr shifts right with s inserted at MSB.
  - sa and sb shift right with 0 fill; carry<=c; counter++.
  - When counter==WIDTH-1 at the edge, go to DONE. On that same edge: sum<=final sr (including the current bit), cout<=c.
- DONE: done=1 for exactly one cycle, then IDLE; or RUN if start=1 in that cycle (back-to-back).
- Latency: the start edge is E0. done is high in the cycle after edge E(WIDTH), i.e. WIDTH cycles after the start edge. Throughput: one result per WIDTH+1 cycles back-to-back.
- busy is 1 exactly in RUN (WIDTH cycles); busy and done are never both 1.
- sum/cout change only on the completion edge. They are not disturbed by start, clear or RUN activity.
- clear:
  - clear=1 at an edge → IDLE, carry and counter zeroed, no done pulse; sum/cout keep their previous values.
  - clear has priority over start in the same cycle.
- Reset mid-RUN: immediate return to the reset values above; no done pulse.
- WIDTH=1: RUN lasts one cycle; the counter is ≥1 bit wide (max(1, clog2(WIDTH))).
- Arithmetic is modulo 2^WIDTH, with the overflow bit reported on cout; the result equals a+b+cin exactly.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the counter-width function.
- One sub-module is natural: fa_bit_cell, a purely combinational 1-bit full adder (x, y, z → s, c). Exactly one instance, driven from sa[0], sb[0] and the carry flop. All sequencing stays in the parent.

Test Plan:
- WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulse → busy high 8 cycles; done pulse on the 8th cycle after the start edge; sum=0x96, cout=0.
- WIDTH=8: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Start held high in RUN with changed a/b → ignored; first result is unaffected. Start high during DONE → a second run begins without an IDLE cycle, and its result is correct.
- rst_n pulled low at RUN cycle 4 → busy=0, done=0, sum=0, cout=0 immediately. After release, a new start (0x12+0x34) → sum=0x46.
- clear at RUN cycle 3 (with start also high) → IDLE, no done pulse, sum/cout keep the previous result. A subsequent start completes normally.
- WIDTH=1 build: a=1, b=1, cin=1 → done one cycle after the start edge; sum=1, cout=1.
